// File: rtl/xadc_drp_sequencer_pkg.sv
// Shared constants for the XADC DRP read sequencer: FSM encodings,
// control-word bit positions and DRP widths.
package xadc_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_WAIT_EOC  = 3'd1;
    localparam state_t ST_REQ       = 3'd2;
    localparam state_t ST_WAIT_RDY  = 3'd3;
    localparam state_t ST_WRITEBACK = 3'd4;
    localparam state_t ST_COOLDOWN  = 3'd5;

    localparam int START_BIT = 0;
    localparam int DONE_BIT  = 1;
    localparam int ADDR_LSB  = 8;
    localparam int ADDR_MSB  = 15;

    localparam int          DRP_ADDR_W   = 7;
    localparam logic [11:0] TIMEOUT_FILL = 12'hFFF;

endpackage

// File: rtl/xadc_drp_sequencer_if.sv
// DRP port bundle between the sequencer (master) and the XADC primitive (slave).
interface xadc_drp_sequencer_if;
    import xadc_pkg::*;

    // den is a one-cycle request carrying daddr; the XADC answers later with a
    // one-cycle drdy carrying do_in. eoc is an unsolicited one-cycle pulse.
    logic                  den;
    logic                  dwe;
    logic [DRP_ADDR_W-1:0] daddr;
    logic                  eoc;
    logic                  drdy;
    logic [15:0]           do_in;

    modport master (output den, dwe, daddr, input eoc, drdy, do_in);
    modport slave  (input den, dwe, daddr, output eoc, drdy, do_in);

endinterface

// File: rtl/xadc_drp_sequencer.sv
// Runs one DRP read per start request from the XADC control register and
// writes the 12-bit result plus a done flag back to the register file.
module xadc_drp_sequencer
    import xadc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          WAIT_EOC       = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [31:0]                 control_in,
    xadc_drp_sequencer_if.master        drp,
    output logic [1:0]                  control_int,
    output logic                        we_ctrl,
    output logic [31:0]                 data_out,
    output logic                        we_data,
    output logic                        busy,
    output logic                        timeout_err,
    output state_t                      state_dbg
);

    localparam logic [15:0] TO_LOAD = 16'(TIMEOUT_CYCLES);

    state_t                state;
    logic [DRP_ADDR_W-1:0] addr_q;
    logic [11:0]           data_q;
    logic [15:0]           cnt;
    logic                  start_req;
    logic                  unused_bits;

    assign start_req = control_in[START_BIT] && !control_in[DONE_BIT];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        addr_q      <= control_in[ADDR_LSB +: DRP_ADDR_W];
                        timeout_err <= 1'b0;
                        state       <= WAIT_EOC ? ST_WAIT_EOC : ST_REQ;
                    end
                end
                ST_WAIT_EOC: begin
                    if (drp.eoc) state <= ST_REQ;
                end
                ST_REQ: begin
                    cnt   <= TO_LOAD;
                    state <= ST_WAIT_RDY;
                end
                ST_WAIT_RDY: begin
                    // A response landing on the expiry cycle still wins.
                    if (drp.drdy) begin
                        data_q <= drp.do_in[15:4];
                        state  <= ST_WRITEBACK;
                    end else if (cnt == 16'd0) begin
                        timeout_err <= 1'b1;
                        data_q      <= TIMEOUT_FILL;
                        state       <= ST_WRITEBACK;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                ST_WRITEBACK: state <= ST_COOLDOWN;
                // Gives the control register a cycle to show done before IDLE looks again.
                ST_COOLDOWN:  state <= ST_IDLE;
                default:      state <= ST_IDLE;
            endcase
        end
    end

    assign drp.den     = (state == ST_REQ);
    assign drp.dwe     = 1'b0;
    assign drp.daddr   = (state == ST_REQ || state == ST_WAIT_RDY) ? addr_q : '0;
    assign we_ctrl     = (state == ST_WRITEBACK);
    assign we_data     = (state == ST_WRITEBACK);
    assign control_int = {we_ctrl, 1'b0};
    assign data_out    = {20'b0, data_q};
    assign busy        = (state != ST_IDLE);
    assign state_dbg   = state;

    assign unused_bits = ^{control_in[31:ADDR_MSB], control_in[7:2], drp.do_in[3:0]};

endmodule
